// File: rtl/w_stage_writeback.sv
// Write-back stage: selects the W-stage result, commits it to the 32x32 register file
// and serves two D-stage read ports with write-through bypass. Optional macro: WB_TRACE_EN.
module w_stage_writeback #(
    parameter logic [31:0] PC_LINK_OFS = 32'd8,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_ALU_O,
    input  logic [31:0]      W_DM_O,
    input  logic [31:0]      W_PC,
    input  logic [31:0]      W_EXT_O,
    input  logic [31:0]      W_CMP_O,
    input  logic [31:0]      W_MUXMDSrc_O,
    input  logic [31:0]      W_CP0_O,
    input  logic [4:0]       W_A3,
    input  logic [2:0]       W_WDSel,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    output logic [31:0]      D_RD1,
    output logic [31:0]      D_RD2,
    output logic [31:0]      W_WD,
    output logic             W_WE,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        SEL_ALU  = 3'd0,
        SEL_DM   = 3'd1,
        SEL_LINK = 3'd2,
        SEL_EXT  = 3'd3,
        SEL_CMP  = 3'd4,
        SEL_MD   = 3'd5,
        SEL_CP0  = 3'd6,
        SEL_RSVD = 3'd7
    } wdSel_e;

    logic [31:0]      gpr_q [32];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        W_WD = 32'h0;
        case (wdSel_e'(W_WDSel))
            SEL_ALU:  W_WD = W_ALU_O;
            SEL_DM:   W_WD = W_DM_O;
            SEL_LINK: W_WD = W_PC + PC_LINK_OFS;
            SEL_EXT:  W_WD = W_EXT_O;
            SEL_CMP:  W_WD = W_CMP_O;
            SEL_MD:   W_WD = W_MUXMDSrc_O;
            SEL_CP0:  W_WD = W_CP0_O;
            SEL_RSVD: W_WD = 32'h0;
            default:  W_WD = 32'h0;
        endcase
    end

    assign W_WE = (W_A3 != 5'd0);

    // Bypass lets a D-stage read see the value being committed on this same edge.
    always_comb begin
        D_RD1 = 32'h0;
        if (D_A1 != 5'd0) begin
            if (W_WE && (D_A1 == W_A3)) begin
                D_RD1 = W_WD;
            end else begin
                D_RD1 = gpr_q[D_A1];
            end
        end
    end

    always_comb begin
        D_RD2 = 32'h0;
        if (D_A2 != 5'd0) begin
            if (W_WE && (D_A2 == W_A3)) begin
                D_RD2 = W_WD;
            end else begin
                D_RD2 = gpr_q[D_A2];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (W_WE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'h0;
            end
            cnt_q <= '0;
        end else begin
            if (W_WE) begin
                gpr_q[W_A3] <= W_WD;
            end
            cnt_q <= cnt_d;
        end
    end

    assign wb_cnt = cnt_q;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && W_WE) begin
            $display("%d@%h: $%d <= %h", $time, W_PC, W_A3, W_WD);
        end
    end
`else
`endif

endmodule

// File: tb/tb_w_stage_writeback.sv
// Self-checking bench for w_stage_writeback: directed cases followed by random traffic
// checked against a register-file model built from the result-select rules.
module tb_w_stage_writeback;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   W_ALU_O, W_DM_O, W_PC, W_EXT_O, W_CMP_O, W_MUXMDSrc_O, W_CP0_O;
    logic [4:0]    W_A3, D_A1, D_A2;
    logic [2:0]    W_WDSel;
    logic [31:0]   D_RD1, D_RD2, W_WD;
    logic          W_WE;
    logic [CW-1:0] wb_cnt;

    logic [31:0]   mGpr [32];
    int unsigned   mCnt;
    int            compared = 0;
    int            mismatched = 0;

    always #5 clk = ~clk;

    w_stage_writeback #(.PC_LINK_OFS(32'd8), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .W_ALU_O(W_ALU_O), .W_DM_O(W_DM_O), .W_PC(W_PC), .W_EXT_O(W_EXT_O),
        .W_CMP_O(W_CMP_O), .W_MUXMDSrc_O(W_MUXMDSrc_O), .W_CP0_O(W_CP0_O),
        .W_A3(W_A3), .W_WDSel(W_WDSel), .D_A1(D_A1), .D_A2(D_A2),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .W_WD(W_WD), .W_WE(W_WE), .wb_cnt(wb_cnt)
    );

    // Reference result: a plain table lookup on the select code.
    function automatic logic [31:0] expWd();
        logic [31:0] src [8];
        src[0] = W_ALU_O;       src[1] = W_DM_O;
        src[2] = W_PC + 32'd8;  src[3] = W_EXT_O;
        src[4] = W_CMP_O;       src[5] = W_MUXMDSrc_O;
        src[6] = W_CP0_O;       src[7] = 32'h0;
        return src[W_WDSel];
    endfunction

    function automatic logic [31:0] expRd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (W_A3 != 5'd0 && a == W_A3) return expWd();
        return mGpr[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".W_WD"}, W_WD, expWd());
        checkOutput({tag, ".W_WE"}, {31'h0, W_WE}, {31'h0, (W_A3 != 5'd0)});
        checkOutput({tag, ".wb_cnt"}, {{(32-CW){1'b0}}, wb_cnt}, mCnt);
        if (!reset) begin
            checkOutput({tag, ".D_RD1"}, D_RD1, expRd(D_A1));
            checkOutput({tag, ".D_RD2"}, D_RD2, expRd(D_A2));
        end
    endtask

    task automatic applyStimulus(input logic [4:0] a3, input logic [2:0] sel,
                                 input logic [4:0] a1, input logic [4:0] a2);
        W_A3 = a3; W_WDSel = sel; D_A1 = a1; D_A2 = a2;
        #1;
    endtask

    // Advance one clock, applying the commit rules to the model at the edge.
    task automatic stepClock();
        if (reset) begin
            for (int i = 0; i < 32; i++) mGpr[i] = 32'h0;
            mCnt = 0;
        end else if (W_A3 != 5'd0) begin
            mGpr[W_A3] = expWd();
            mCnt = (mCnt + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mGpr[i] = 32'h0;
        mCnt = 0;
        reset = 1'b1;
        W_ALU_O = 0; W_DM_O = 0; W_PC = 0; W_EXT_O = 0; W_CMP_O = 0;
        W_MUXMDSrc_O = 0; W_CP0_O = 0;
        applyStimulus(5'd0, 3'd0, 5'd0, 5'd0);
        @(negedge clk);
        stepClock();
        stepClock();
        reset = 1'b0;

        // Reset state
        applyStimulus(5'd0, 3'd0, 5'd5, 5'd31);
        checkOutput("rst.RD1", D_RD1, 32'h0);
        checkOutput("rst.RD2", D_RD2, 32'h0);
        checkOutput("rst.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'h0);
        checkOutput("rst.WE", {31'h0, W_WE}, 32'h0);

        // ALU commit to r3, read back next cycle
        W_ALU_O = 32'h1234_5678;
        applyStimulus(5'd3, 3'd0, 5'd0, 5'd0);
        checkAll("alu");
        stepClock();
        applyStimulus(5'd0, 3'd0, 5'd3, 5'd0);
        checkOutput("alu.RD1", D_RD1, 32'h1234_5678);
        checkOutput("alu.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'd1);

        // Link write to r31 with same-cycle bypass
        W_PC = 32'h0000_3010;
        applyStimulus(5'd31, 3'd2, 5'd0, 5'd31);
        checkOutput("link.WD", W_WD, 32'h0000_3018);
        checkOutput("link.byp", D_RD2, 32'h0000_3018);
        stepClock();
        applyStimulus(5'd0, 3'd0, 5'd0, 5'd31);
        checkOutput("link.RD2", D_RD2, 32'h0000_3018);

        // No write when destination is r0
        W_DM_O = 32'hFFFF_FFFF;
        applyStimulus(5'd0, 3'd1, 5'd0, 5'd3);
        checkOutput("r0.WE", {31'h0, W_WE}, 32'h0);
        checkOutput("r0.RD1", D_RD1, 32'h0);
        stepClock();
        checkOutput("r0.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'd2);

        // Sweep every select code into r8
        W_ALU_O = 32'hA000_0001; W_DM_O = 32'hD000_0002; W_PC = 32'h0000_4000;
        W_EXT_O = 32'h5A5A_0000; W_CMP_O = 32'h0000_0001; W_MUXMDSrc_O = 32'hC0DE_0005;
        W_CP0_O = 32'h0000_0010;
        for (int s = 0; s < 8; s++) begin
            applyStimulus(5'd8, 3'(s), 5'd8, 5'd31);
            checkAll("sweep");
            stepClock();
        end
        applyStimulus(5'd0, 3'd0, 5'd8, 5'd0);
        checkOutput("sweep.sel7", D_RD1, 32'h0);
        checkOutput("sweep.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'd10);

        // Counter wrap: 17 commits from zero lands on 1
        reset = 1'b1;
        applyStimulus(5'd0, 3'd0, 5'd0, 5'd0);
        stepClock();
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            W_ALU_O = 32'h100 + k;
            applyStimulus(5'(1 + k % 31), 3'd0, 5'd0, 5'd0);
            stepClock();
        end
        checkOutput("wrap.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'd1);

        // Reset wins over a valid write
        reset = 1'b1;
        W_ALU_O = 32'hDEAD_BEEF;
        applyStimulus(5'd4, 3'd0, 5'd0, 5'd0);
        stepClock();
        reset = 1'b0;
        applyStimulus(5'd0, 3'd0, 5'd4, 5'd1);
        checkOutput("rstwr.RD1", D_RD1, 32'h0);
        checkOutput("rstwr.RD2", D_RD2, 32'h0);
        checkOutput("rstwr.cnt", {{(32-CW){1'b0}}, wb_cnt}, 32'h0);

        // Random traffic with occasional mid-stream reset
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 24) == 0);
            W_ALU_O = $urandom; W_DM_O = $urandom; W_PC = $urandom; W_EXT_O = $urandom;
            W_CMP_O = $urandom; W_MUXMDSrc_O = $urandom; W_CP0_O = $urandom;
            applyStimulus(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) D_A1 = W_A3;
            if ($urandom_range(0, 3) == 0) D_A2 = W_A3;
            #1;
            checkAll("rand");
            stepClock();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
